// File: rtl/sram_gpu_pkg.sv
// Shared constants for the GPU SRAM macro model: default geometry and active-low pin encodings.
package sram_gpu_pkg;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_AW = 11;
  localparam int DEPTH      = 2 ** DEFAULT_AW;

  localparam logic CEN_ACTIVE  = 1'b0;
  localparam logic WEN_WRITE   = 1'b0;
  localparam logic RETN_RETAIN = 1'b0;

endpackage

// File: rtl/sram_gpu_if.sv
// Pin bundle of one compiled-memory instance (CEN, WEN, A, D, EMA, RETN, Q).
// Handshake: no valid/ready; an access is requested by CEN=0 on a rising CLK and Q is valid one edge later.
interface sram_gpu_if #(
  parameter int DW = sram_gpu_pkg::DEFAULT_DW,
  parameter int AW = sram_gpu_pkg::DEFAULT_AW
) ();
  logic          CEN;
  logic          WEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [2:0]    EMA;
  logic          RETN;
  logic [DW-1:0] Q;

  modport master (output CEN, WEN, A, D, EMA, RETN, input Q);
  modport slave  (input CEN, WEN, A, D, EMA, RETN, output Q);
endinterface

// File: rtl/sram_gpu_array.sv
// Storage array with a synchronous write port and asynchronous read of the addressed word.
// With SRAM_GPU_ZERO_INIT_EN defined, every word is cleared while reset is low.
module sram_gpu_array #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
`ifdef SRAM_GPU_ZERO_INIT_EN
  input  logic          rst_n,
`endif
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int NWORDS = 1 << AW;

  logic [DW-1:0] mem [NWORDS];

  assign rdata = mem[addr];

`ifdef SRAM_GPU_ZERO_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
`else
  // No reset on the array: contents written before a reset survive it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
`endif

endmodule

// File: rtl/sram_gpu_model.sv
// Behavioural single-port synchronous SRAM macro: control decode, retention gating and the Q register.
// Optional macro SRAM_GPU_ZERO_INIT_EN clears the array while RSTN is low.
module sram_gpu_model
  import sram_gpu_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic       CLK,
  input  logic       RSTN,
  sram_gpu_if.slave  bus
);

  logic          retain;
  logic          access;
  logic          write;
  logic          read;
  logic [DW-1:0] rdata;
  logic [DW-1:0] q_reg;

  // EMA only trims timing on silicon, so it is intentionally not decoded here.
  assign retain = (bus.RETN == RETN_RETAIN);
  assign access = !retain && (bus.CEN == CEN_ACTIVE);
  assign write  = access && (bus.WEN == WEN_WRITE);
  assign read   = access && (bus.WEN != WEN_WRITE);

  sram_gpu_array #(
    .DW (DW),
    .AW (AW)
  ) u_array (
    .clk   (CLK),
`ifdef SRAM_GPU_ZERO_INIT_EN
    .rst_n (RSTN),
`endif
    .we    (write),
    .addr  (bus.A),
    .wdata (bus.D),
    .rdata (rdata)
  );

  // Clearing q_reg during retention keeps Q at 0 after RETN returns, until the next access.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_reg <= '0;
    end else if (retain) begin
      q_reg <= '0;
    end else if (write) begin
      q_reg <= bus.D;
    end else if (read) begin
      q_reg <= rdata;
    end
  end

  assign bus.Q = retain ? '0 : q_reg;

endmodule

// File: tb/tb_sram_gpu_model.sv
// Self-checking bench: two instances sharing A/D as in the banked wrapper, checked against a scoreboard.
module tb_sram_gpu_model;
  import sram_gpu_pkg::*;

  localparam int DW = DEFAULT_DW;
  localparam int AW = DEFAULT_AW;
`ifdef SRAM_GPU_ZERO_INIT_EN
  localparam bit ZERO_INIT = 1'b1;
`else
  localparam bit ZERO_INIT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_gpu_if #(.DW(DW), .AW(AW)) bus1 ();
  sram_gpu_if #(.DW(DW), .AW(AW)) bus2 ();

  sram_gpu_model #(.DW(DW), .AW(AW)) u_sram1 (.CLK(clk), .RSTN(rst_n), .bus(bus1));
  sram_gpu_model #(.DW(DW), .AW(AW)) u_sram2 (.CLK(clk), .RSTN(rst_n), .bus(bus2));

  // ---------------- scoreboard / model state ----------------
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   mem1[int];
  logic [DW-1:0]   mem2[int];
  logic [DW-1:0]   q1_m;
  logic [DW-1:0]   q2_m;
  int              checks;
  int              passed;

  function automatic logic [DW-1:0] unwritten_value();
    return ZERO_INIT ? '0 : 'x;
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one cycle on both instances (shared A/D), updates the model and queues the expected {Q2,Q1}.
  task automatic step(input logic cen, input logic wen1, input logic wen2,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic retn);
    @(negedge clk);
    bus1.CEN  = cen;  bus2.CEN  = cen;
    bus1.WEN  = wen1; bus2.WEN  = wen2;
    bus1.A    = a;    bus2.A    = a;
    bus1.D    = d;    bus2.D    = d;
    bus1.RETN = retn; bus2.RETN = retn;
    bus1.EMA  = 3'($urandom_range(0, 7));
    bus2.EMA  = 3'($urandom_range(0, 7));
    if (!retn) begin
      q1_m = '0;
      q2_m = '0;
    end else if (!cen) begin
      if (!wen1) begin mem1[int'(a)] = d; q1_m = d; end
      else q1_m = mem1.exists(int'(a)) ? mem1[int'(a)] : unwritten_value();
      if (!wen2) begin mem2[int'(a)] = d; q2_m = d; end
      else q2_m = mem2.exists(int'(a)) ? mem2[int'(a)] : unwritten_value();
    end
    exp_q.push_back({q2_m, q1_m});
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle so the bench can observe Q before the next rising edge.
  task automatic assert_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    q1_m = '0;
    q2_m = '0;
    if (ZERO_INIT) begin
      mem1.delete();
      mem2.delete();
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [2*DW-1:0] exp;
    logic [2*DW-1:0] got;
    #1;
    got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== '0) $display("FAIL reset_initial: got %h expected %h", got, 16'h0000);
    else passed++;
    release_reset();

    step(1'b0, 1'b0, 1'b0, 11'h055, 8'hA5, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp) $display("FAIL reset_preload: got %h expected %h", got, exp);
    else passed++;

    assert_reset();
    got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== 16'h0000) $display("FAIL reset_async: got %h expected %h", got, 16'h0000);
    else passed++;

    @(posedge clk); #1;
    got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== 16'h0000) $display("FAIL reset_hold: got %h expected %h", got, 16'h0000);
    else passed++;
    release_reset();

    // First edge after reset is a normal read.
    step(1'b0, 1'b1, 1'b1, 11'h055, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp) $display("FAIL reset_first_access: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_write_read();
    logic [2*DW-1:0] exp;
    logic [2*DW-1:0] got;
    step(1'b0, 1'b0, 1'b0, 11'h010, 8'h3C, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'h3C3C) $display("FAIL write_through: got %h expected %h", got, exp);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 11'h011, 8'h99, 1'b1);
    void'(exp_q.pop_front());
    step(1'b0, 1'b1, 1'b1, 11'h010, 8'hEE, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'h3C3C) $display("FAIL write_then_read: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_idle_hold();
    logic [2*DW-1:0] exp;
    logic [2*DW-1:0] got;
    step(1'b0, 1'b0, 1'b0, 11'h7FF, 8'h5A, 1'b1);
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0, 11'h000, 8'h77, 1'b1);
    void'(exp_q.pop_front());
    step(1'b0, 1'b1, 1'b1, 11'h7FF, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp) $display("FAIL idle_read: got %h expected %h", got, exp);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           (i == 0) ? 11'h7FF : 11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)), 1'b1);
      exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
      checks++;
      if (got !== exp || got !== 16'h5A5A) $display("FAIL idle_hold[%0d]: got %h expected %h", i, got, exp);
      else passed++;
    end
    step(1'b0, 1'b1, 1'b1, 11'h7FF, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'h5A5A) $display("FAIL idle_mem_unchanged: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_banked_pair();
    logic [2*DW-1:0] exp;
    logic [2*DW-1:0] got;
    step(1'b0, 1'b0, 1'b0, 11'h001, 8'h00, 1'b1);
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b1, 11'h001, 8'h11, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp) $display("FAIL bank_write1: got %h expected %h", got, exp);
    else passed++;
    step(1'b0, 1'b1, 1'b0, 11'h001, 8'h22, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp) $display("FAIL bank_write2: got %h expected %h", got, exp);
    else passed++;
    step(1'b0, 1'b1, 1'b1, 11'h001, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'h2211) $display("FAIL bank_read: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] exp;
    logic [2*DW-1:0] got;
    logic [AW-1:0]   addrs[8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 11'($urandom_range(11'h200, 11'h2FF));
      step(1'b0, 1'b0, 1'b0, addrs[i], 8'($urandom_range(0, 255)), 1'b1);
      void'(exp_q.pop_front());
      // Read-after-write on the very next cycle.
      step(1'b0, 1'b1, 1'b1, addrs[i], 8'($urandom_range(0, 255)), 1'b1);
      exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
      checks++;
      if (got !== exp) $display("FAIL raw[%0d]: got %h expected %h", i, got, exp);
      else passed++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, addrs[i], 8'h00, 1'b1);
      exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
      checks++;
      if (got !== exp) $display("FAIL b2b_read[%0d]: got %h expected %h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_address_edges();
    logic [2*DW-1:0] exp;
    logic [2*DW-1:0] got;
    step(1'b0, 1'b0, 1'b0, 11'h000, 8'hC1, 1'b1);
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0, 11'h7FF, 8'h1C, 1'b1);
    void'(exp_q.pop_front());
    step(1'b0, 1'b1, 1'b1, 11'h000, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'hC1C1) $display("FAIL addr_low: got %h expected %h", got, exp);
    else passed++;
    step(1'b0, 1'b1, 1'b1, 11'h7FF, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'h1C1C) $display("FAIL addr_high: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_retention();
    logic [2*DW-1:0] exp;
    logic [2*DW-1:0] got;
    step(1'b0, 1'b0, 1'b0, 11'h123, 8'hF0, 1'b1);
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0, 11'h123, 8'h0F, 1'b0);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'h0000) $display("FAIL retn_write_blocked: got %h expected %h", got, exp);
    else passed++;
    step(1'b1, 1'b1, 1'b1, 11'h000, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'h0000) $display("FAIL retn_exit_q_zero: got %h expected %h", got, exp);
    else passed++;
    step(1'b0, 1'b1, 1'b1, 11'h123, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== 16'hF0F0) $display("FAIL retn_preserved: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_zero_init();
    logic [2*DW-1:0] exp;
    logic [2*DW-1:0] got;
    step(1'b0, 1'b0, 1'b0, 11'h400, 8'hFF, 1'b1);
    void'(exp_q.pop_front());
    assert_reset();
    release_reset();
    step(1'b0, 1'b1, 1'b1, 11'h400, 8'h00, 1'b1);
    exp = exp_q.pop_front(); got = {bus2.Q, bus1.Q};
    checks++;
    if (got !== exp || got !== (ZERO_INIT ? 16'h0000 : 16'hFFFF))
      $display("FAIL zero_init_read: got %h expected %h", got, exp);
    else passed++;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0;
    passed = 0;
    q1_m = '0;
    q2_m = '0;
    rst_n = 1'b0;
    bus1.CEN = 1'b1; bus2.CEN = 1'b1;
    bus1.WEN = 1'b1; bus2.WEN = 1'b1;
    bus1.A = '0; bus2.A = '0;
    bus1.D = '0; bus2.D = '0;
    bus1.EMA = 3'b000; bus2.EMA = 3'b000;
    bus1.RETN = 1'b1; bus2.RETN = 1'b1;

    test_reset();
    test_write_read();
    test_idle_hold();
    test_banked_pair();
    test_back_to_back();
    test_address_edges();
    test_retention();
    test_zero_init();

    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/sram_gpu_model.md
Name: sram_gpu_model

Overview:
- Behavioural single-port synchronous SRAM macro model for the GPU datapath.
- Default size is 2048 words x 8 bits.
- Used in pairs by the GPU SRAM wrapper. Both instances share address and data-in. Write enables are steered by a bank-select bit, and the two Q outputs are concatenated into a 2*DW read word.
- Pin set follows the foundry compiled-memory convention (CEN, WEN, A, D, Q, EMA, RETN), plus an async active-low reset.

Parameters:
- DW, 8, data word width in bits.
- AW, 11, address width; array depth is 2**AW words.

Ports:
- CLK  in  1  clock; all accesses sample on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- CEN  in  1  chip enable, active low.
- WEN  in  1  write enable, active low; meaningful only when CEN=0.
- A  in  AW  word address.
- D  in  DW  write data.
- EMA  in  3  extra margin adjust; timing-only, no functional effect; the wrapper ties it to 3'b000.
- RETN  in  1  retention control, active low; the wrapper ties it to 1.
- Q  out  DW  registered read data.

Behaviour:
- Reset: RSTN=0 asynchronously forces Q to 0 and holds it there while low.
  - Array contents are untouched by reset unless SRAM_GPU_ZERO_INIT_EN is defined.
- First edge after RSTN rises performs a normal access.
- All actions below are on rising CLK with RSTN=1 and RETN=1.
- Read (CEN=0, WEN=1): Q <= mem[A].
  - Latency is 1 cycle: data is visible after the edge that sampled A.
- Write (CEN=0, WEN=0): mem[A] <= D and Q <= D (write-through).
- Idle (CEN=1): no array access; Q holds its previous value; WEN, A and D are ignored.
- Read-after-write to the same address on the next cycle returns the new data; there is no bypass hazard.
- Back-to-back reads on consecutive cycles are supported at full rate.
- Addressing is full decode; all 2**AW addresses are valid; there is no wrap or alias logic.
- Retention (RETN=0):
  - Array contents are preserved.
  - All accesses are ignored.
  - Q is driven to 0.
  - When RETN returns to 1, Q stays 0 until the next read or write.
- EMA: any value is accepted and has no effect on function or latency.
- Unwritten locations read X in simulation when SRAM_GPU_ZERO_INIT_EN is not defined.
- Shared-address pairs:
  - When two instances share A and D but only one has WEN=0, only that instance's array changes.
  - Both instances update Q, the writer via write-through and the other via a normal read.

Optional Feature:
- Macro: SRAM_GPU_ZERO_INIT_EN.
- Defined: while RSTN=0, every array word is asynchronously cleared to 0. After reset, any read of an unwritten address returns 0.
- Not defined: the array has no reset. Contents after power-up are X; contents written before a reset survive it.

Decomposition:
- Package sram_gpu_pkg holds:
  - default DW=8 and AW=11 constants;
  - a derived DEPTH constant (2**AW);
  - localparams for the active-low encodings of CEN, WEN and RETN.
- One sub-module is natural: sram_gpu_array, the storage plus write port with optional zero-clear. The top level holds control decode, retention gating and the Q register.

Test Plan:
- Reset: RSTN=0 with Q previously 8'hA5 -> Q=0 immediately, asynchronously, before any CLK edge.
- Write then read: write D=8'h3C at A=11'h010, then read A=11'h010 -> Q=8'h3C one cycle after the read edge.
  - Q also equals 8'h3C right after the write edge (write-through).
- Idle hold: read A=0x7FF holding 8'h5A, then CEN=1 for 3 cycles with A and D toggling -> Q stays 8'h5A; mem unchanged.
- Banked pair: two instances, inst1 WEN=0 and inst2 WEN=1, A=0x001, D=8'h11. Then swap enables with D=8'h22. Then read A=0x001 from both -> concatenated {Q2,Q1}=16'h2211.
- Retention: write 8'hF0 at 0x123, set RETN=0 and attempt a write of 8'h0F -> Q=0. Set RETN=1 and read 0x123 -> Q=8'hF0.
- Zero-init (macro defined): pulse RSTN low after writing 8'hFF at 0x400, then read 0x400 -> Q=8'h00.
  - Without the macro the same sequence returns 8'hFF.
